// File: rtl/pio_param_bridge_pkg.sv
// Shared constants for the PIO <-> NCO/lock-in bridge: control-word bit map,
// default widths and the commit FSM state encoding.
package pio_bridge_pkg;

  localparam int CB_COMMIT = 0;
  localparam int CB_SEL_LO = 1;
  localparam int CB_SEL_HI = 3;
  localparam int CB_SNAP   = 4;
  localparam int CB_TCLR   = 5;

  localparam int N_CH_DEF         = 8;
  localparam int PH_W_DEF         = 20;
  localparam int LIA_W_DEF        = 16;
  localparam int SYNC_TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_APPLY     = 2'd2
  } commit_state_e;

endpackage

// File: rtl/pio_param_bridge_if.sv
// Signal bundle between qsys_system PIO exports and the NCO/lock-in array.
// master = CPU/fabric side driving PIO words, slave = the bridge.
interface pio_param_bridge_if
  import pio_bridge_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int PH_W  = PH_W_DEF,
  parameter int LIA_W = LIA_W_DEF
) ();

  logic [N_CH*PH_W-1:0]  pio_incr;
  logic [N_CH*PH_W-1:0]  pio_offs;
  logic [7:0]            pio_ctrl;
  logic                  sync_tick;
  logic [N_CH*LIA_W-1:0] lia_x;
  logic [N_CH*LIA_W-1:0] lia_y;
  logic                  lia_valid;
  logic [N_CH*PH_W-1:0]  nco_incr;
  logic [N_CH*PH_W-1:0]  nco_offs;
  logic                  nco_load;
  logic [LIA_W-1:0]      rb_x;
  logic [LIA_W-1:0]      rb_y;
  logic                  timeout_flag;

  modport master (
    output pio_incr, pio_offs, pio_ctrl, sync_tick, lia_x, lia_y, lia_valid,
    input  nco_incr, nco_offs, nco_load, rb_x, rb_y, timeout_flag
  );

  modport slave (
    input  pio_incr, pio_offs, pio_ctrl, sync_tick, lia_x, lia_y, lia_valid,
    output nco_incr, nco_offs, nco_load, rb_x, rb_y, timeout_flag
  );

endinterface

// File: rtl/pio_param_bridge_toggle_edge_det.sv
// Converts a CPU-written toggle bit into a one-cycle pulse on each change.
// Primed out of reset so the value present at reset release never fires.
module toggle_edge_det
  import pio_bridge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_toggle,
  output logic o_pulse
);

  logic r_prev;
  logic r_primed;

  // NOTE: r_prev follows the input even during reset, so the first compare
  // after reset sees the live toggle value and cannot produce a false edge.
  always_ff @(posedge clk) begin
    r_prev <= i_toggle;
    if (rst) r_primed <= 1'b0;
    else     r_primed <= 1'b1;
  end

  assign o_pulse = r_primed & (i_toggle ^ r_prev);

endmodule

// File: rtl/pio_param_bridge.sv
// Applies CPU phase words to the NCO bank atomically at a sync boundary and
// snapshots lock-in X/Y results for per-channel CPU readback.
module pio_param_bridge
  import pio_bridge_pkg::*;
#(
  parameter int N_CH         = N_CH_DEF,
  parameter int PH_W         = PH_W_DEF,
  parameter int LIA_W        = LIA_W_DEF,
  parameter int SYNC_TIMEOUT = SYNC_TIMEOUT_DEF
) (
  input logic               clk_clk,
  input logic               reset_reset,
  pio_param_bridge_if.slave bus
);

  localparam int PW    = N_CH * PH_W;
  localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);

  logic [PW-1:0]    r_incr_sh;
  logic [PW-1:0]    r_offs_sh;
  logic [5:0]       r_ctrl;
  logic             w_unused_ctrl;
  logic             w_commit_pulse;
  logic             w_snap_pulse;

  commit_state_e    r_state;
  commit_state_e    w_state_nxt;
  logic             w_apply;
  logic             w_timeout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_held;
  logic [PW-1:0]    r_pend_incr;
  logic [PW-1:0]    r_pend_offs;
  logic [PW-1:0]    w_pend_incr;
  logic [PW-1:0]    w_pend_offs;
  logic [PW-1:0]    r_nco_incr;
  logic [PW-1:0]    r_nco_offs;
  logic             r_nco_load;
  logic             r_timeout_flag;

  logic             r_armed;
  logic [LIA_W-1:0] r_snap_x [N_CH];
  logic [LIA_W-1:0] r_snap_y [N_CH];
  logic [2:0]       w_sel;
  logic [LIA_W-1:0] r_rb_x;
  logic [LIA_W-1:0] r_rb_y;

  assign w_unused_ctrl = ^bus.pio_ctrl[7:6];

  // NOTE: shadow registers are deliberately left out of reset: they are a
  // pure pipeline stage and must track pio_ctrl so the edge detectors prime.
  always_ff @(posedge clk_clk) begin
    r_incr_sh <= bus.pio_incr;
    r_offs_sh <= bus.pio_offs;
    r_ctrl    <= bus.pio_ctrl[5:0];
  end

  toggle_edge_det u_commit_det (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .i_toggle (r_ctrl[CB_COMMIT]),
    .o_pulse  (w_commit_pulse)
  );

  toggle_edge_det u_snap_det (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .i_toggle (r_ctrl[CB_SNAP]),
    .o_pulse  (w_snap_pulse)
  );

  // A commit edge arriving together with the apply decision is the newest word.
  assign w_pend_incr = w_commit_pulse ? r_incr_sh : r_pend_incr;
  assign w_pend_offs = w_commit_pulse ? r_offs_sh : r_pend_offs;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_commit_pulse || r_held) w_state_nxt = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (bus.sync_tick) begin
          w_state_nxt = ST_APPLY;
          w_apply     = 1'b1;
        end else if (r_cnt == CNT_W'(SYNC_TIMEOUT - 1)) begin
          w_state_nxt = ST_APPLY;
          w_apply     = 1'b1;
          w_timeout   = 1'b1;
        end
      end
      ST_APPLY: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // nco_incr/offs update on the same edge that raises nco_load, so the load
  // pulse always coincides with the new words.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_held         <= 1'b0;
      r_pend_incr    <= '0;
      r_pend_offs    <= '0;
      r_nco_incr     <= '0;
      r_nco_offs     <= '0;
      r_nco_load     <= 1'b0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_nco_load <= w_apply;
      if (w_commit_pulse) begin
        r_pend_incr <= r_incr_sh;
        r_pend_offs <= r_offs_sh;
      end
      if (w_apply) begin
        r_nco_incr <= w_pend_incr;
        r_nco_offs <= w_pend_offs;
      end
      if (r_state == ST_IDLE)           r_cnt <= '0;
      else if (r_state == ST_WAIT_SYNC) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == ST_APPLY && w_commit_pulse) r_held <= 1'b1;
      else if (r_state == ST_IDLE)               r_held <= 1'b0;
      if (w_timeout)            r_timeout_flag <= 1'b1;
      else if (r_ctrl[CB_TCLR]) r_timeout_flag <= 1'b0;
    end
  end

  // NOTE: the snapshot bank is small and must read back as zero after reset,
  // so unlike a RAM it is explicitly cleared.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_armed <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_snap_x[i] <= '0;
        r_snap_y[i] <= '0;
      end
    end else begin
      r_armed <= w_snap_pulse | (r_armed & ~bus.lia_valid);
      if (r_armed && bus.lia_valid) begin
        for (int i = 0; i < N_CH; i++) begin
          r_snap_x[i] <= bus.lia_x[i*LIA_W +: LIA_W];
          r_snap_y[i] <= bus.lia_y[i*LIA_W +: LIA_W];
        end
      end
    end
  end

  assign w_sel = r_ctrl[CB_SEL_HI:CB_SEL_LO];

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rb_x <= '0;
      r_rb_y <= '0;
    end else if (int'(w_sel) < N_CH) begin
      r_rb_x <= r_snap_x[w_sel];
      r_rb_y <= r_snap_y[w_sel];
    end else begin
      r_rb_x <= '0;
      r_rb_y <= '0;
    end
  end

  assign bus.nco_incr     = r_nco_incr;
  assign bus.nco_offs     = r_nco_offs;
  assign bus.nco_load     = r_nco_load;
  assign bus.rb_x         = r_rb_x;
  assign bus.rb_y         = r_rb_y;
  assign bus.timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_pio_param_bridge.sv
// Self-checking bench for pio_param_bridge: scenario tasks with inline checks
// against a cycle-count model of commit timing, snapshot and readback.
module tb_pio_param_bridge;
  import pio_bridge_pkg::*;

  localparam int N_CH  = 8;
  localparam int PH_W  = 20;
  localparam int LIA_W = 16;
  localparam int TO    = 16;
  localparam int PW    = N_CH * PH_W;
  localparam int LW    = N_CH * LIA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pio_param_bridge_if #(.N_CH(N_CH), .PH_W(PH_W), .LIA_W(LIA_W)) bus ();

  pio_param_bridge #(
    .N_CH(N_CH), .PH_W(PH_W), .LIA_W(LIA_W), .SYNC_TIMEOUT(TO)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the NCO bank and readback should currently show.
  logic [PW-1:0]    m_incr;
  logic [PW-1:0]    m_offs;
  logic             m_flag;
  logic [7:0]       m_ctrl;
  logic [LIA_W-1:0] m_snap_x [N_CH];
  logic [LIA_W-1:0] m_snap_y [N_CH];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [7:0] c);
    m_ctrl       = c;
    bus.pio_ctrl = c;
  endtask

  function automatic logic [PW-1:0] rand_ph();
    logic [PW-1:0] v;
    for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [LW-1:0] rand_lia();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [2*LIA_W-1:0] model_rb();
    int sel;
    sel = int'(m_ctrl[3:1]);
    if (sel < N_CH) return {m_snap_x[sel], m_snap_y[sel]};
    return '0;
  endfunction

  task automatic model_reset();
    m_incr = '0;
    m_offs = '0;
    m_flag = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      m_snap_x[i] = '0;
      m_snap_y[i] = '0;
    end
  endtask

  // Commit toggled before edge 0; the first tick at edge >= 2 applies, else
  // timeout applies at edge 1+TO. Ticks at edges 0/1 must be ignored.
  task automatic run_commit(input logic [PW-1:0] incr, input logic [PW-1:0] offs,
                            input int tick_at, input bit early, input string name);
    int apply_at;
    bit timed;
    timed    = (tick_at > 1 + TO);
    apply_at = timed ? 1 + TO : tick_at;
    bus.pio_incr = incr;
    bus.pio_offs = offs;
    set_ctrl(m_ctrl ^ 8'h01);
    for (int k = 0; k <= apply_at + 2; k++) begin
      bus.sync_tick = (k == tick_at) || (early && k < 2);
      cyc();
      if (bus.nco_load !== (k == apply_at)) begin
        $display("FAIL %s nco_load edge %0d: got %0b expected %0b", name, k,
                 bus.nco_load, (k == apply_at));
      end else n_pass++;
      n_checks++;
      if (k < apply_at) begin
        if (bus.nco_incr !== m_incr) begin
          $display("FAIL %s early_apply edge %0d: got %h expected %h", name, k,
                   bus.nco_incr, m_incr);
        end else n_pass++;
        n_checks++;
      end
    end
    bus.sync_tick = 1'b0;
    m_incr = incr;
    m_offs = offs;
    m_flag = m_flag | timed;
    if ({bus.nco_incr, bus.nco_offs} !== {m_incr, m_offs}) begin
      $display("FAIL %s words: got %h/%h expected %h/%h", name, bus.nco_incr,
               bus.nco_offs, m_incr, m_offs);
    end else n_pass++;
    n_checks++;
    if (bus.timeout_flag !== m_flag) begin
      $display("FAIL %s timeout_flag: got %0b expected %0b", name,
               bus.timeout_flag, m_flag);
    end else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.pio_incr  = '0;
    bus.pio_offs  = '0;
    set_ctrl(8'h11);
    bus.sync_tick = 1'b0;
    bus.lia_x     = '0;
    bus.lia_y     = '0;
    bus.lia_valid = 1'b0;
    model_reset();
    repeat (4) cyc();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.sync_tick = 1'($urandom_range(0, 1));
      bus.lia_valid = 1'($urandom_range(0, 1));
      bus.lia_x     = rand_lia();
      bus.lia_y     = rand_lia();
      cyc();
      if ({bus.nco_load, bus.timeout_flag, bus.rb_x, bus.rb_y} !== '0) begin
        $display("FAIL reset ctl/rb cycle %0d: got %0b/%0b/%h/%h expected all zero", k,
                 bus.nco_load, bus.timeout_flag, bus.rb_x, bus.rb_y);
      end else n_pass++;
      n_checks++;
      if ({bus.nco_incr, bus.nco_offs} !== {m_incr, m_offs}) begin
        $display("FAIL reset nco cycle %0d: got %h/%h expected zero", k,
                 bus.nco_incr, bus.nco_offs);
      end else n_pass++;
      n_checks++;
    end
    bus.sync_tick = 1'b0;
    bus.lia_valid = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic test_tick_commit();
    logic [PW-1:0] incr;
    incr = m_incr;
    incr[2*PH_W +: PH_W] = 20'h12345;
    run_commit(incr, m_offs, 10, 1'b0, "tick_commit");
  endtask

  task automatic test_timeout();
    run_commit(rand_ph(), rand_ph(), 1000, 1'b0, "timeout");
    set_ctrl(m_ctrl | 8'h20);
    cyc();
    if (bus.timeout_flag !== m_flag) begin
      $display("FAIL tclr_hold: got %0b expected %0b", bus.timeout_flag, m_flag);
    end else n_pass++;
    n_checks++;
    cyc();
    m_flag = 1'b0;
    if (bus.timeout_flag !== m_flag) begin
      $display("FAIL tclr: got %0b expected %0b", bus.timeout_flag, m_flag);
    end else n_pass++;
    n_checks++;
    set_ctrl(m_ctrl & ~8'h20);
    repeat (2) cyc();
  endtask

  task automatic test_double_commit();
    logic [PW-1:0] a, b, offs;
    a    = rand_ph();
    b    = rand_ph();
    b[PH_W-1:0] = a[PH_W-1:0] ^ 20'h00001;
    offs = rand_ph();
    bus.pio_incr = a;
    bus.pio_offs = offs;
    set_ctrl(m_ctrl ^ 8'h01);
    for (int k = 0; k <= 10; k++) begin
      if (k == 3) begin
        bus.pio_incr = b;
        set_ctrl(m_ctrl ^ 8'h01);
      end
      bus.sync_tick = (k == 8);
      cyc();
      if (bus.nco_load !== (k == 8)) begin
        $display("FAIL double nco_load edge %0d: got %0b expected %0b", k,
                 bus.nco_load, (k == 8));
      end else n_pass++;
      n_checks++;
    end
    bus.sync_tick = 1'b0;
    m_incr = b;
    m_offs = offs;
    if ({bus.nco_incr, bus.nco_offs} !== {m_incr, m_offs}) begin
      $display("FAIL double words: got %h/%h expected %h/%h", bus.nco_incr,
               bus.nco_offs, m_incr, m_offs);
    end else n_pass++;
    n_checks++;
    repeat (2) cyc();
  endtask

  task automatic test_snapshot();
    logic [LW-1:0] d0x, d0y, d1x, d1y;
    d0x = rand_lia();
    d0y = rand_lia();
    d0x[4*LIA_W +: LIA_W] = 16'h1111;
    d0y[4*LIA_W +: LIA_W] = 16'h1111;
    d1x = rand_lia();
    d1y = rand_lia();
    d1x[4*LIA_W +: LIA_W] = 16'hBEEF;
    d1y[4*LIA_W +: LIA_W] = 16'h0042;
    set_ctrl(((m_ctrl & ~8'h0E) | 8'h08) ^ 8'h10);
    cyc();
    bus.lia_x     = d0x;
    bus.lia_y     = d0y;
    bus.lia_valid = 1'b1;
    cyc();
    bus.lia_valid = 1'b0;
    repeat (2) cyc();
    bus.lia_x     = d1x;
    bus.lia_y     = d1y;
    bus.lia_valid = 1'b1;
    cyc();
    bus.lia_valid = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      m_snap_x[i] = d1x[i*LIA_W +: LIA_W];
      m_snap_y[i] = d1y[i*LIA_W +: LIA_W];
    end
    cyc();
    if ({bus.rb_x, bus.rb_y} !== {16'hBEEF, 16'h0042}) begin
      $display("FAIL snap_ch5: got %h/%h expected beef/0042", bus.rb_x, bus.rb_y);
    end else n_pass++;
    n_checks++;
    for (int s = 0; s < N_CH; s++) begin
      set_ctrl((m_ctrl & ~8'h0E) | 8'(s << 1));
      repeat (2) cyc();
      if ({bus.rb_x, bus.rb_y} !== model_rb()) begin
        $display("FAIL readback sel %0d: got %h/%h expected %h", s, bus.rb_x,
                 bus.rb_y, model_rb());
      end else n_pass++;
      n_checks++;
    end
    set_ctrl((m_ctrl & ~8'h0E) | 8'h08);
    repeat (2) cyc();
    for (int k = 0; k < 4; k++) begin
      bus.lia_x     = rand_lia();
      bus.lia_y     = rand_lia();
      bus.lia_valid = 1'b1;
      cyc();
      if ({bus.rb_x, bus.rb_y} !== {16'hBEEF, 16'h0042}) begin
        $display("FAIL snap_stable cycle %0d: got %h/%h expected beef/0042", k,
                 bus.rb_x, bus.rb_y);
      end else n_pass++;
      n_checks++;
    end
    bus.lia_valid = 1'b0;
    cyc();
  endtask

  task automatic test_random_commits();
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        set_ctrl(m_ctrl | 8'h20);
        repeat (2) cyc();
        m_flag = 1'b0;
        set_ctrl(m_ctrl & ~8'h20);
        cyc();
      end
      run_commit(rand_ph(), rand_ph(), int'($urandom_range(2, 24)),
                 1'($urandom_range(0, 1)), "rand_commit");
    end
  endtask

  task automatic test_reset_mid_wait();
    bus.pio_incr = rand_ph();
    bus.pio_offs = rand_ph();
    set_ctrl(m_ctrl ^ 8'h01);
    repeat (3) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      bus.sync_tick = (k == 2) || (k == 5);
      cyc();
      if (bus.nco_load !== 1'b0) begin
        $display("FAIL rst_wait nco_load cycle %0d: got %0b expected 0", k, bus.nco_load);
      end else n_pass++;
      n_checks++;
      if ({bus.nco_incr, bus.nco_offs, bus.rb_x, bus.rb_y, bus.timeout_flag} !==
          {m_incr, m_offs, model_rb(), m_flag}) begin
        $display("FAIL rst_wait outputs cycle %0d: got %h/%h/%h/%h/%0b expected zero", k,
                 bus.nco_incr, bus.nco_offs, bus.rb_x, bus.rb_y, bus.timeout_flag);
      end else n_pass++;
      n_checks++;
    end
    bus.sync_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick_commit();
    test_timeout();
    test_double_commit();
    test_snapshot();
    test_random_commits();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pio_param_bridge.md
Name: pio_param_bridge

Overview:
Fabric-side counterpart of the qsys_system PIO exports. It consumes the CPU-written phase_incr/phase_offs/control_bits words and applies them atomically to the 8-channel NCO bank at a safe sync boundary. In the other direction it snapshots the 8 lock-in X/Y results and drives one selected channel onto the 16-bit lia_1_x/lia_1_y inputs for CPU readback. It sits between qsys_system and the NCO/lock-in array.

Parameters:
N_CH, 8, number of NCO/lock-in channels (select field in control bits is 3 bits; N_CH ≤ 8)
PH_W, 20, phase increment/offset width
LIA_W, 16, lock-in X/Y result width
SYNC_TIMEOUT, 1024, cycles to wait for sync_tick before forced apply

Ports:
clk_clk  in  1  system clock (same domain as qsys_system)
reset_reset  in  1  synchronous, active-high reset
pio_incr  in  N_CH*PH_W  flattened phase_incr_1..8 exports, ch1 in LSBs
pio_offs  in  N_CH*PH_W  flattened phase_offs_1..8 exports, ch1 in LSBs
pio_ctrl  in  8  control_bits export
sync_tick  in  1  NCO bank safe-update strobe (accumulator wrap of ch1)
lia_x  in  N_CH*LIA_W  flattened lock-in X results
lia_y  in  N_CH*LIA_W  flattened lock-in Y results
lia_valid  in  1  one-cycle strobe: lia_x/lia_y are new
nco_incr  out  N_CH*PH_W  active phase increments to NCO bank
nco_offs  out  N_CH*PH_W  active phase offsets to NCO bank
nco_load  out  1  one-cycle pulse when nco_incr/nco_offs change
rb_x  out  LIA_W  to lia_1_x_export
rb_y  out  LIA_W  to lia_1_y_export
timeout_flag  out  1  sticky: last commit was forced by timeout

Behaviour:
- Clock clk_clk; reset synchronous, active-high; all state updated on rising edge.
- Control bits: [0] commit toggle, [3:1] readback channel select, [4] snapshot toggle, [5] timeout_flag clear (level), [7:6] reserved/ignored.
- Input stage: pio_incr/pio_offs/pio_ctrl registered once (shadow regs); toggle edges are detected on registered pio_ctrl vs. its previous value.
- Reset: nco_incr=0, nco_offs=0, nco_load=0, rb_x=0, rb_y=0, timeout_flag=0, snapshots=0, FSM=IDLE, previous-toggle regs loaded from pio_ctrl on the first post-reset cycle (no spurious commit/snapshot).
- Commit FSM states IDLE, WAIT_SYNC, APPLY.
  - IDLE: commit-toggle edge -> WAIT_SYNC, latch shadow into a pending buffer, clear timeout counter.
  - WAIT_SYNC: sync_tick=1 -> APPLY. Counter reaches SYNC_TIMEOUT-1 without tick -> APPLY and set timeout_flag.
  - APPLY (1 cycle): nco_incr/nco_offs <= pending; nco_load=1 this cycle only; -> IDLE.
  - Commit-toggle edge while in WAIT_SYNC: re-latch pending (newest wins), counter not restarted. Edge in APPLY: held and serviced on return to IDLE (one outstanding edge max; further edges coalesce).
  - sync_tick coincident with commit edge in IDLE: not used; wait for the next tick.
- Latency: commit edge at PIO -> nco_load ≥ 3 cycles (register, detect, WAIT_SYNC≥1, APPLY).
- timeout_flag: set in timeout APPLY; cleared by ctrl[5]=1 (set wins if simultaneous).
- Snapshot: snapshot-toggle edge arms capture; next lia_valid copies all N_CH X/Y into the snapshot bank and disarms. lia_valid coincident with the edge is not captured. Without an edge, lia_valid is ignored (readback stable for CPU).
- Readback: rb_x/rb_y = snapshot[sel] registered, 1-cycle latency after sel or snapshot change. sel ≥ N_CH -> rb_x=rb_y=0.
- Widths exact; no arithmetic on phase words (pass-through).
- Reset mid-WAIT_SYNC: pending discarded, outputs return to 0.

Decomposition:
- Package pio_bridge_pkg: control-bit index constants (CB_COMMIT=0, CB_SEL_LO=1, CB_SEL_HI=3, CB_SNAP=4, CB_TCLR=5), FSM state enum, default widths.
- One sub-module, toggle_edge_det (registered toggle -> one-cycle pulse, reset-primed), instantiated for commit and snapshot.

Test Plan:
- Reset with pio_ctrl=8'h11 preset -> no nco_load, no capture; all outputs 0 for 20 cycles.
- Write incr_3=20'h12345, toggle ctrl[0]; sync_tick at cycle +10 -> nco_load single pulse the cycle after the tick, ch3 incr=20'h12345, other channels unchanged.
- Commit with sync_tick held 0, SYNC_TIMEOUT=16 -> apply at the 16th WAIT_SYNC cycle, timeout_flag=1; ctrl[5]=1 -> flag 0 next cycle.
- Two commit toggles 3 cycles apart in WAIT_SYNC with different incr_1 -> single nco_load with second value.
- Toggle ctrl[4], lia_valid with x_5=16'hBEEF, y_5=16'h0042, sel=4 (ch5) -> rb_x=16'hBEEF, rb_y=16'h0042; later lia_valid without toggle -> readback unchanged.
- Reset asserted in WAIT_SYNC, then tick -> no nco_load, nco_incr stays 0.
